axicb_slv_wr_arbiter: RTL and testbench

Per-slave write-path arbiter of the crossbar: shares one slave agent's AW/W/B channels among up to four master-side write switches. AW requests are granted round-robin. The winner's index is queued so W beats follow AW order, and B responses are routed back to the issuing master by ID prefix. It sits between the master-side write switches and one slave port.

---
 rtl/axicb_slv_wr_arbiter_pkg.sv | 26 ++
 rtl/axicb_slv_wr_arbiter_if.sv | 36 +++
 rtl/axicb_round_robin.sv | 32 +++
 rtl/axicb_scfifo.sv | 53 +++++
 rtl/axicb_slv_wr_arbiter.sv | 92 +++++++++
 tb/tb_axicb_slv_wr_arbiter.sv | 204 ++++++++++++++++++++
 6 files changed

// File: rtl/axicb_slv_wr_arbiter_pkg.sv
// rtl/axicb_slv_wr_arbiter_pkg.sv - shared constants and helpers for the slave write arbiter
// Purpose: master count, one-hot/index helpers and the round-robin priority mask.
// Ports: none (package).
package axicb_slv_wr_arbiter_pkg;

  localparam int MST_NB    = 4;
  localparam int MST_IDX_W = 2;

  typedef logic [MST_NB-1:0]    mst_vec_t;
  typedef logic [MST_IDX_W-1:0] mst_idx_t;

  function automatic mst_idx_t onehot_to_idx(input mst_vec_t oh);
    mst_idx_t idx;
    idx = '0;
    for (int i = 0; i < MST_NB; i++) begin
      if (oh[i]) idx = idx | MST_IDX_W'(i);
    end
    return idx;
  endfunction

  // Requesters at or above the pointer get first pick.
  function automatic mst_vec_t rr_mask(input mst_idx_t ptr);
    return mst_vec_t'({MST_NB{1'b1}} << ptr);
  endfunction

endpackage

// File: rtl/axicb_slv_wr_arbiter_if.sv
// rtl/axicb_slv_wr_arbiter_if.sv - AW/W/B bundle between master-side switches and one slave
// Purpose: groups the per-master (i_*) and slave-side (o_*) write channels.
// Ports: slave modport = arbiter view, master modport = surrounding fabric view.
interface axicb_slv_wr_arbiter_if #(
  parameter int MST_NB = 4,
  parameter int AWCH_W = 8,
  parameter int WCH_W  = 8,
  parameter int BCH_W  = 10
);
  logic [MST_NB-1:0]        i_awvalid, i_awready;
  logic [MST_NB*AWCH_W-1:0] i_awch;
  logic [MST_NB-1:0]        i_wvalid, i_wready, i_wlast;
  logic [MST_NB*WCH_W-1:0]  i_wch;
  logic [MST_NB-1:0]        i_bvalid, i_bready;
  logic [BCH_W-1:0]         i_bch;
  logic                     o_awvalid, o_awready;
  logic [AWCH_W-1:0]        o_awch;
  logic                     o_wvalid, o_wready, o_wlast;
  logic [WCH_W-1:0]         o_wch;
  logic                     o_bvalid, o_bready;
  logic [BCH_W-1:0]         o_bch;

  modport slave (
    input  i_awvalid, i_awch, i_wvalid, i_wlast, i_wch, i_bready,
    input  o_awready, o_wready, o_bvalid, o_bch,
    output i_awready, i_wready, i_bvalid, i_bch,
    output o_awvalid, o_awch, o_wvalid, o_wlast, o_wch, o_bready
  );

  modport master (
    output i_awvalid, i_awch, i_wvalid, i_wlast, i_wch, i_bready,
    output o_awready, o_wready, o_bvalid, o_bch,
    input  i_awready, i_wready, i_bvalid, i_bch,
    input  o_awvalid, o_awch, o_wvalid, o_wlast, o_wch, o_bready
  );
endinterface

// File: rtl/axicb_round_robin.sv
// rtl/axicb_round_robin.sv - round-robin arbiter with handshake-driven pointer
// Purpose: combinational one-hot grant; pointer moves to granted+1 when en is high.
// Ports: clk, rst_n (async), srst (sync), req, en, grant.
module axicb_round_robin
  import axicb_slv_wr_arbiter_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     srst,
  input  mst_vec_t req,
  input  logic     en,
  output mst_vec_t grant
);
  mst_idx_t ptr_q, ptr_d;
  mst_vec_t masked, pick_src;

  assign masked   = req & rr_mask(ptr_q);
  assign pick_src = (|masked) ? masked : req;
  // Isolate the lowest set bit.
  assign grant    = pick_src & (~pick_src + mst_vec_t'(1));

  always_comb begin
    ptr_d = ptr_q;
    if (en && (|grant)) ptr_d = onehot_to_idx(grant) + MST_IDX_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    ptr_q <= '0;
    else if (srst) ptr_q <= '0;
    else           ptr_q <= ptr_d;
  end
endmodule

// File: rtl/axicb_scfifo.sv
// rtl/axicb_scfifo.sv - single-clock FIFO with optional empty pass-through
// Purpose: small queue; PASS_THRU=0 means a push is visible only the cycle after.
// Ports: clk, rst_n (async), srst (sync), push/in_data/full, pop/out_data/empty.
module axicb_scfifo #(
  parameter int DATA_WIDTH = 4,
  parameter int DEPTH_W    = 3,
  parameter int PASS_THRU  = 0
)(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  srst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  full,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  empty
);
  logic [DATA_WIDTH-1:0] mem [2**DEPTH_W];
  logic [DEPTH_W-1:0]    wptr_q, rptr_q;
  logic [DEPTH_W:0]      count_q, count_d;
  logic                  bypass, do_push, do_pop;

  assign bypass   = (PASS_THRU != 0) && (count_q == '0);
  assign full     = (count_q == (DEPTH_W+1)'(1 << DEPTH_W));
  assign empty    = bypass ? ~push : (count_q == '0);
  assign out_data = bypass ? in_data : mem[rptr_q];
  // A bypassed word consumed in the same cycle never touches storage.
  assign do_push  = push & ~full & ~(bypass & pop);
  assign do_pop   = pop & ~empty & ~bypass;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop)      count_d = count_q + (DEPTH_W+1)'(1);
    else if (!do_push && do_pop) count_d = count_q - (DEPTH_W+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0; rptr_q <= '0; count_q <= '0;
    end else if (srst) begin
      wptr_q <= '0; rptr_q <= '0; count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + DEPTH_W'(1);
      if (do_pop)  rptr_q <= rptr_q + DEPTH_W'(1);
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/axicb_slv_wr_arbiter.sv
// rtl/axicb_slv_wr_arbiter.sv - per-slave write-path arbiter of the crossbar
// Purpose: round-robin AW grant with lock, W ordering via grant FIFO, B routing by ID prefix.
// Ports: aclk, aresetn (async, low), srst (sync, high), bus (slave modport of the write bundle).
module axicb_slv_wr_arbiter
  import axicb_slv_wr_arbiter_pkg::*;
#(
  parameter int                  AXI_ID_W      = 8,
  parameter logic [AXI_ID_W-1:0] MST0_ID_MASK  = 'h10,
  parameter logic [AXI_ID_W-1:0] MST1_ID_MASK  = 'h20,
  parameter logic [AXI_ID_W-1:0] MST2_ID_MASK  = 'h40,
  parameter logic [AXI_ID_W-1:0] MST3_ID_MASK  = 'h80,
  parameter int                  WFIFO_DEPTH_W = 3,
  parameter int                  AWCH_W        = 8,
  parameter int                  WCH_W         = 8,
  parameter int                  BCH_W         = 10
)(
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  srst,
  axicb_slv_wr_arbiter_if.slave bus
);
  localparam logic [AXI_ID_W-1:0] ROUTE_MASK =
    MST0_ID_MASK | MST1_ID_MASK | MST2_ID_MASK | MST3_ID_MASK;

  mst_vec_t rr_req, rr_grant, grant_q, grant_d, head, head_v, b_hit;
  logic     lock_q, lock_d, full, empty, aw_hs, w_pop;
  mst_idx_t aw_idx, w_idx;
  logic [AXI_ID_W-1:0] bid;

  // While locked only the held winner is offered, so the arbiter cannot
  // switch away and the pointer advances from the master actually served.
  assign rr_req = lock_q ? grant_q : bus.i_awvalid;

  axicb_round_robin u_rr (
    .clk(aclk), .rst_n(aresetn), .srst(srst),
    .req(rr_req), .en(aw_hs), .grant(rr_grant)
  );

  assign aw_idx        = onehot_to_idx(rr_grant);
  assign bus.o_awvalid = (|bus.i_awvalid) & ~full;
  assign bus.o_awch    = bus.i_awch[aw_idx*AWCH_W +: AWCH_W];
  assign bus.i_awready = {MST_NB{bus.o_awready & ~full}} & rr_grant;
  assign aw_hs         = bus.o_awvalid & bus.o_awready;

  always_comb begin
    grant_d = grant_q;
    lock_d  = lock_q;
    if (bus.o_awvalid) begin
      grant_d = rr_grant;
      lock_d  = ~bus.o_awready;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      grant_q <= '0; lock_q <= 1'b0;
    end else if (srst) begin
      grant_q <= '0; lock_q <= 1'b0;
    end else begin
      grant_q <= grant_d; lock_q <= lock_d;
    end
  end

  axicb_scfifo #(.DATA_WIDTH(MST_NB), .DEPTH_W(WFIFO_DEPTH_W), .PASS_THRU(0)) u_wfifo (
    .clk(aclk), .rst_n(aresetn), .srst(srst),
    .push(aw_hs), .in_data(rr_grant), .full(full),
    .pop(w_pop), .out_data(head), .empty(empty)
  );

  // Masking with empty keeps stale storage from ever selecting a master.
  assign head_v       = empty ? '0 : head;
  assign w_idx        = onehot_to_idx(head_v);
  assign bus.o_wvalid = |(bus.i_wvalid & head_v);
  assign bus.o_wlast  = |(bus.i_wlast & head_v);
  assign bus.o_wch    = bus.i_wch[w_idx*WCH_W +: WCH_W];
  assign bus.i_wready = {MST_NB{bus.o_wready}} & head_v;
  assign w_pop        = bus.o_wvalid & bus.o_wready & bus.o_wlast;

  assign bid = bus.o_bch[0 +: AXI_ID_W];
  always_comb begin
    b_hit    = '0;
    b_hit[0] = (bid & ROUTE_MASK) == MST0_ID_MASK;
    b_hit[1] = (bid & ROUTE_MASK) == MST1_ID_MASK;
    b_hit[2] = (bid & ROUTE_MASK) == MST2_ID_MASK;
    b_hit[3] = (bid & ROUTE_MASK) == MST3_ID_MASK;
  end

  assign bus.i_bch    = bus.o_bch;
  assign bus.i_bvalid = {MST_NB{bus.o_bvalid}} & b_hit;
  // Unroutable responses are drained so the slave never stalls on them.
  assign bus.o_bready = (|b_hit) ? |(b_hit & bus.i_bready) : 1'b1;
endmodule

// File: tb/tb_axicb_slv_wr_arbiter.sv
// tb/tb_axicb_slv_wr_arbiter.sv - directed self-checking bench for axicb_slv_wr_arbiter
module tb_axicb_slv_wr_arbiter;
  logic aclk = 1'b0;
  logic aresetn;
  logic srst;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 aclk = ~aclk;

  axicb_slv_wr_arbiter_if #(.MST_NB(4), .AWCH_W(8), .WCH_W(8), .BCH_W(10)) bus ();

  axicb_slv_wr_arbiter dut (.aclk(aclk), .aresetn(aresetn), .srst(srst), .bus(bus));

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic idle();
    bus.i_awvalid = '0; bus.i_awch = '0;
    bus.i_wvalid  = '0; bus.i_wlast = '0; bus.i_wch = '0;
    bus.i_bready  = '0;
    bus.o_awready = 1'b0; bus.o_wready = 1'b0;
    bus.o_bvalid  = 1'b0; bus.o_bch = '0;
  endtask

  task automatic pulse_srst();
    idle();
    srst = 1'b1;
    tick();
    srst = 1'b0;
  endtask

  task automatic test_reset();
    aresetn = 1'b0; srst = 1'b0;
    idle();
    #2;
    vectors++; if (bus.o_awvalid !== 1'b0) begin miscompares++; $display("FAIL reset_awvalid got %b exp 0", bus.o_awvalid); end
    vectors++; if (bus.o_wvalid !== 1'b0) begin miscompares++; $display("FAIL reset_wvalid got %b exp 0", bus.o_wvalid); end
    vectors++; if (bus.o_wlast !== 1'b0) begin miscompares++; $display("FAIL reset_wlast got %b exp 0", bus.o_wlast); end
    vectors++; if (bus.i_awready !== 4'b0000) begin miscompares++; $display("FAIL reset_awready got %b exp 0000", bus.i_awready); end
    vectors++; if (bus.i_wready !== 4'b0000) begin miscompares++; $display("FAIL reset_wready got %b exp 0000", bus.i_wready); end
    vectors++; if (bus.i_bvalid !== 4'b0000) begin miscompares++; $display("FAIL reset_bvalid got %b exp 0000", bus.i_bvalid); end
    vectors++; if (bus.o_bready !== 1'b1) begin miscompares++; $display("FAIL reset_bready got %b exp 1", bus.o_bready); end
    aresetn = 1'b1;
    tick();
  endtask

  task automatic test_single();
    bus.i_awvalid = 4'b0001; bus.i_awch[7:0] = 8'hA5; bus.o_awready = 1'b1;
    bus.i_wvalid = 4'b0001; bus.i_wch[7:0] = 8'h30; bus.o_wready = 1'b1;
    #1;
    vectors++; if (bus.o_awvalid !== 1'b1) begin miscompares++; $display("FAIL single_awvalid got %b exp 1", bus.o_awvalid); end
    vectors++; if (bus.o_awch !== 8'hA5) begin miscompares++; $display("FAIL single_awch got %h exp a5", bus.o_awch); end
    vectors++; if (bus.i_awready !== 4'b0001) begin miscompares++; $display("FAIL single_awready got %b exp 0001", bus.i_awready); end
    vectors++; if (bus.o_wvalid !== 1'b0) begin miscompares++; $display("FAIL single_w_before_aw got %b exp 0", bus.o_wvalid); end
    vectors++; if (bus.i_wready !== 4'b0000) begin miscompares++; $display("FAIL single_wready_before_aw got %b exp 0000", bus.i_wready); end
    tick();
    bus.i_awvalid = '0;
    for (int b = 0; b < 4; b++) begin
      bus.i_wch[7:0] = 8'h30 + 8'(b);
      bus.i_wlast[0] = (b == 3);
      #1;
      vectors++; if (bus.o_wvalid !== 1'b1) begin miscompares++; $display("FAIL single_wvalid beat %0d got %b exp 1", b, bus.o_wvalid); end
      vectors++; if (bus.o_wch !== 8'h30 + 8'(b)) begin miscompares++; $display("FAIL single_wch beat %0d got %h exp %h", b, bus.o_wch, 8'h30 + 8'(b)); end
      vectors++; if (bus.o_wlast !== (b == 3)) begin miscompares++; $display("FAIL single_wlast beat %0d got %b exp %b", b, bus.o_wlast, (b == 3)); end
      vectors++; if (bus.i_wready !== 4'b0001) begin miscompares++; $display("FAIL single_wready beat %0d got %b exp 0001", b, bus.i_wready); end
      tick();
    end
    bus.i_wvalid = '0; bus.i_wlast = '0;
    #1;
    vectors++; if (bus.i_wready !== 4'b0000) begin miscompares++; $display("FAIL single_fifo_drained got %b exp 0000", bus.i_wready); end
    bus.o_bvalid = 1'b1; bus.o_bch = {2'b01, 8'h11}; bus.i_bready = 4'b0001;
    #1;
    vectors++; if (bus.i_bvalid !== 4'b0001) begin miscompares++; $display("FAIL single_bvalid got %b exp 0001", bus.i_bvalid); end
    vectors++; if (bus.o_bready !== 1'b1) begin miscompares++; $display("FAIL single_bready got %b exp 1", bus.o_bready); end
    vectors++; if (bus.i_bch !== 10'h111) begin miscompares++; $display("FAIL single_bch got %h exp 111", bus.i_bch); end
    bus.i_bready = 4'b0000;
    #1;
    vectors++; if (bus.o_bready !== 1'b0) begin miscompares++; $display("FAIL single_bready_low got %b exp 0", bus.o_bready); end
    idle();
    tick();
  endtask

  task automatic test_round_robin();
    pulse_srst();
    bus.i_awvalid = 4'b1111; bus.i_awch = 32'hC3C2C1C0; bus.o_awready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      vectors++; if (bus.i_awready !== 4'(1 << (i % 4))) begin miscompares++; $display("FAIL rr_grant %0d got %b exp %b", i, bus.i_awready, 4'(1 << (i % 4))); end
      vectors++; if (bus.o_awch !== 8'hC0 + 8'(i % 4)) begin miscompares++; $display("FAIL rr_awch %0d got %h exp %h", i, bus.o_awch, 8'hC0 + 8'(i % 4)); end
      tick();
    end
    #1;
    vectors++; if (bus.o_awvalid !== 1'b0) begin miscompares++; $display("FAIL rr_full_awvalid got %b exp 0", bus.o_awvalid); end
    pulse_srst();
  endtask

  task automatic test_lock();
    bus.i_awch = 32'hC3C2C1C0;
    bus.i_awvalid = 4'b0100; bus.o_awready = 1'b0;
    #1;
    vectors++; if (bus.o_awvalid !== 1'b1) begin miscompares++; $display("FAIL lock_awvalid got %b exp 1", bus.o_awvalid); end
    vectors++; if (bus.i_awready !== 4'b0000) begin miscompares++; $display("FAIL lock_awready_stalled got %b exp 0000", bus.i_awready); end
    tick();
    bus.i_awvalid = 4'b0110;
    for (int c = 0; c < 5; c++) begin
      #1;
      vectors++; if (bus.o_awch !== 8'hC2) begin miscompares++; $display("FAIL lock_hold cycle %0d got %h exp c2", c, bus.o_awch); end
      tick();
    end
    bus.o_awready = 1'b1;
    #1;
    vectors++; if (bus.i_awready !== 4'b0100) begin miscompares++; $display("FAIL lock_release got %b exp 0100", bus.i_awready); end
    tick();
    bus.i_awvalid = 4'b0011;
    #1;
    vectors++; if (bus.i_awready !== 4'b0001) begin miscompares++; $display("FAIL lock_ptr_wrap got %b exp 0001", bus.i_awready); end
    tick();
    #1;
    vectors++; if (bus.i_awready !== 4'b0010) begin miscompares++; $display("FAIL lock_ptr_next got %b exp 0010", bus.i_awready); end
    pulse_srst();
  endtask

  task automatic test_fifo_full();
    bus.i_awvalid = 4'b1000; bus.i_awch = 32'hC3C2C1C0; bus.o_awready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      vectors++; if (bus.i_awready !== 4'b1000) begin miscompares++; $display("FAIL full_fill %0d got %b exp 1000", i, bus.i_awready); end
      tick();
    end
    #1;
    vectors++; if (bus.o_awvalid !== 1'b0) begin miscompares++; $display("FAIL full_ninth_awvalid got %b exp 0", bus.o_awvalid); end
    vectors++; if (bus.i_awready !== 4'b0000) begin miscompares++; $display("FAIL full_ninth_awready got %b exp 0000", bus.i_awready); end
    bus.i_wvalid = 4'b1000; bus.i_wlast = 4'b1000; bus.i_wch = 32'h77000000; bus.o_wready = 1'b1;
    #1;
    vectors++; if (bus.i_wready !== 4'b1000) begin miscompares++; $display("FAIL full_pop_wready got %b exp 1000", bus.i_wready); end
    vectors++; if (bus.o_wch !== 8'h77) begin miscompares++; $display("FAIL full_pop_wch got %h exp 77", bus.o_wch); end
    vectors++; if (bus.o_awvalid !== 1'b0) begin miscompares++; $display("FAIL full_same_cycle_awvalid got %b exp 0", bus.o_awvalid); end
    tick();
    bus.i_wvalid = '0; bus.i_wlast = '0;
    #1;
    vectors++; if (bus.o_awvalid !== 1'b1) begin miscompares++; $display("FAIL full_after_pop_awvalid got %b exp 1", bus.o_awvalid); end
    vectors++; if (bus.i_awready !== 4'b1000) begin miscompares++; $display("FAIL full_after_pop_awready got %b exp 1000", bus.i_awready); end
    pulse_srst();
  endtask

  task automatic test_b_routing();
    bus.o_bvalid = 1'b1; bus.o_bch = {2'b10, 8'h05}; bus.i_bready = 4'b0000;
    #1;
    vectors++; if (bus.i_bvalid !== 4'b0000) begin miscompares++; $display("FAIL b_nomatch_bvalid got %b exp 0000", bus.i_bvalid); end
    vectors++; if (bus.o_bready !== 1'b1) begin miscompares++; $display("FAIL b_nomatch_bready got %b exp 1", bus.o_bready); end
    bus.o_bch = {2'b00, 8'h83}; bus.i_bready = 4'b0111;
    #1;
    vectors++; if (bus.i_bvalid !== 4'b1000) begin miscompares++; $display("FAIL b_mst3_bvalid got %b exp 1000", bus.i_bvalid); end
    vectors++; if (bus.o_bready !== 1'b0) begin miscompares++; $display("FAIL b_mst3_bready_low got %b exp 0", bus.o_bready); end
    bus.i_bready = 4'b1000;
    #1;
    vectors++; if (bus.o_bready !== 1'b1) begin miscompares++; $display("FAIL b_mst3_bready got %b exp 1", bus.o_bready); end
    idle();
    tick();
  endtask

  task automatic test_reset_mid_burst();
    bus.i_awvalid = 4'b0010; bus.i_awch = 32'hC3C2C1C0; bus.o_awready = 1'b1;
    #1;
    vectors++; if (bus.i_awready !== 4'b0010) begin miscompares++; $display("FAIL mid_aw got %b exp 0010", bus.i_awready); end
    tick();
    bus.i_awvalid = '0;
    bus.i_wvalid = 4'b0010; bus.i_wlast = 4'b0000; bus.o_wready = 1'b1;
    #1;
    vectors++; if (bus.i_wready !== 4'b0010) begin miscompares++; $display("FAIL mid_beat got %b exp 0010", bus.i_wready); end
    tick();
    #2;
    aresetn = 1'b0;
    #1;
    vectors++; if (bus.o_wvalid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_wvalid got %b exp 0", bus.o_wvalid); end
    vectors++; if (bus.i_wready !== 4'b0000) begin miscompares++; $display("FAIL mid_rst_wready got %b exp 0000", bus.i_wready); end
    vectors++; if (bus.o_awvalid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_awvalid got %b exp 0", bus.o_awvalid); end
    idle();
    tick();
    aresetn = 1'b1;
    tick();
    bus.i_awvalid = 4'b1111; bus.i_awch = 32'hC3C2C1C0; bus.o_awready = 1'b1;
    #1;
    vectors++; if (bus.i_awready !== 4'b0001) begin miscompares++; $display("FAIL mid_after_rst_grant got %b exp 0001", bus.i_awready); end
    vectors++; if (bus.o_awch !== 8'hC0) begin miscompares++; $display("FAIL mid_after_rst_awch got %h exp c0", bus.o_awch); end
    idle();
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_lock();
    test_fifo_full();
    test_b_routing();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
